// File: rtl/cmul_real_share_arb.sv
// cmul_real_share_arb: round-robin sharing of one registered complex-by-real multiplier
// between two requesters, with a tag pipe that routes each product back to its owner.
module cmul_real_share_arb #(
  parameter int WL      = 14,
  parameter int WL_OUT  = 28,
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [WL-1:0]     req0_ar_i,
  input  logic [WL-1:0]     req0_ai_i,
  input  logic [WL-1:0]     req0_br_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [WL-1:0]     req1_ar_i,
  input  logic [WL-1:0]     req1_ai_i,
  input  logic [WL-1:0]     req1_br_i,
  output logic [WL-1:0]     m_ar_o,
  output logic [WL-1:0]     m_ai_o,
  output logic [WL-1:0]     m_br_o,
  input  logic [WL_OUT-1:0] m_cr_i,
  input  logic [WL_OUT-1:0] m_ci_i,
  output logic              rsp0_valid_o,
  output logic              rsp1_valid_o,
  output logic [WL_OUT-1:0] rsp_cr_o,
  output logic [WL_OUT-1:0] rsp_ci_o,
  output logic [CNT_W-1:0]  acc0_cnt_o,
  output logic [CNT_W-1:0]  acc1_cnt_o,
  output logic              busy_o
);
  logic              last_grant_q, last_grant_d;
  logic              xfer0, xfer1, xfer;
  logic [MUL_LAT:0]  tv_q, tv_d, tid_q, tid_d;
  logic [WL-1:0]     m_ar_q, m_ar_d, m_ai_q, m_ai_d, m_br_q, m_br_d;
  logic              rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic [WL_OUT-1:0] rsp_cr_q, rsp_cr_d, rsp_ci_q, rsp_ci_d;
  logic [CNT_W-1:0]  acc0_q, acc0_d, acc1_q, acc1_d;

  // last_grant==1 means requester 0 has priority on the next contention
  assign req0_ready_o = !req1_valid_i || last_grant_q;
  assign req1_ready_o = !req0_valid_i || !last_grant_q;
  assign xfer0 = req0_valid_i && req0_ready_o;
  assign xfer1 = req1_valid_i && req1_ready_o;
  assign xfer  = xfer0 || xfer1;

  always_comb begin
    last_grant_d = xfer ? xfer1 : last_grant_q;
    m_ar_d   = xfer1 ? req1_ar_i : xfer0 ? req0_ar_i : m_ar_q;
    m_ai_d   = xfer1 ? req1_ai_i : xfer0 ? req0_ai_i : m_ai_q;
    m_br_d   = xfer1 ? req1_br_i : xfer0 ? req0_br_i : m_br_q;
    tv_d     = {tv_q[MUL_LAT-1:0], xfer};
    tid_d    = {tid_q[MUL_LAT-1:0], xfer1};
    rsp0_d   = tv_q[MUL_LAT] && !tid_q[MUL_LAT];
    rsp1_d   = tv_q[MUL_LAT] && tid_q[MUL_LAT];
    rsp_cr_d = tv_q[MUL_LAT] ? m_cr_i : rsp_cr_q;
    rsp_ci_d = tv_q[MUL_LAT] ? m_ci_i : rsp_ci_q;
    acc0_d   = (xfer0 && acc0_q != '1) ? acc0_q + 1'b1 : acc0_q;
    acc1_d   = (xfer1 && acc1_q != '1) ? acc1_q + 1'b1 : acc1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= 1'b1;
      m_ar_q       <= '0;
      m_ai_q       <= '0;
      m_br_q       <= '0;
      tv_q         <= '0;
      tid_q        <= '0;
      rsp0_q       <= 1'b0;
      rsp1_q       <= 1'b0;
      rsp_cr_q     <= '0;
      rsp_ci_q     <= '0;
      acc0_q       <= '0;
      acc1_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      m_ar_q       <= m_ar_d;
      m_ai_q       <= m_ai_d;
      m_br_q       <= m_br_d;
      tv_q         <= tv_d;
      tid_q        <= tid_d;
      rsp0_q       <= rsp0_d;
      rsp1_q       <= rsp1_d;
      rsp_cr_q     <= rsp_cr_d;
      rsp_ci_q     <= rsp_ci_d;
      acc0_q       <= acc0_d;
      acc1_q       <= acc1_d;
    end
  end

  assign m_ar_o       = m_ar_q;
  assign m_ai_o       = m_ai_q;
  assign m_br_o       = m_br_q;
  assign rsp0_valid_o = rsp0_q;
  assign rsp1_valid_o = rsp1_q;
  assign rsp_cr_o     = rsp_cr_q;
  assign rsp_ci_o     = rsp_ci_q;
  assign acc0_cnt_o   = acc0_q;
  assign acc1_cnt_o   = acc1_q;
  assign busy_o       = |tv_q;
endmodule

// File: doc/cmul_real_share_arb.md
Name: cmul_real_share_arb

Overview:
- Time-shares one registered complex-by-real multiplier (c = a·br, with cr = ar·br and ci = ai·br) between two independent requesters.
- Arbitrates requests round-robin and drives the shared multiplier's ar/ai/br inputs.
- Tracks request ownership through the multiplier latency with a tag pipeline, and returns each product to its owner as a registered valid pulse.
- Sits between the FFT/filter stage controllers and the single multiplier instance.

Parameters:
WL, 14, signed input word length (ar, ai, br)
WL_OUT, 28, signed product word length (2*WL)
MUL_LAT, 1, clock edges from m_ar/m_ai/m_br update to valid m_cr/m_ci (1..4)
CNT_W, 16, width of per-requester accept counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has operands
req0_ready  out  1  requester 0 may transfer this cycle
req0_ar, req0_ai, req0_br  in  WL each  requester 0 operands, signed
req1_valid  in  1  requester 1 has operands
req1_ready  out  1  requester 1 may transfer this cycle
req1_ar, req1_ai, req1_br  in  WL each  requester 1 operands, signed
m_ar, m_ai, m_br  out  WL each  shared multiplier operands (registered)
m_cr, m_ci  in  WL_OUT each  shared multiplier products
rsp0_valid, rsp1_valid  out  1  one-cycle product-ready pulse per requester
rsp_cr, rsp_ci  out  WL_OUT each  registered product, shared by both requesters
acc0_cnt, acc1_cnt  out  CNT_W each  accepted-request counters, saturating
busy  out  1  any tag in flight

Behaviour:
- Transfer occurs when reqN_valid & reqN_ready are high at a rising edge.
- Readiness:
  - req0_ready = !req1_valid || last_grant==1.
  - req1_ready = !req0_valid || last_grant==0.
  - Readiness is combinational from valids and last_grant only, never from reqN_ready.
  - At most one transfer occurs per edge. If both are valid, exactly one ready is high.
- last_grant updates to N on each transfer by N. It holds when no transfer occurs. Reset value is 1, so requester 0 wins the first contention.
- On a transfer edge, m_ar/m_ai/m_br load the winner's operands; otherwise they hold their previous values.
- Tag pipe: MUL_LAT+1 stages of {v, id}.
  - Stage 0 loads {transfer, winner} on every edge.
  - Each later stage shifts on every edge; there is no stall and no back-pressure on responses.
- When the final stage has v=1:
  - rsp_cr/rsp_ci register m_cr/m_ci on that edge.
  - rsp{id}_valid = 1 for exactly the following cycle.
  - When no final-stage tag is valid, rsp_cr/rsp_ci hold their values and both rsp valids are 0.
- Latency: a transfer at edge E gives rspN_valid high in the cycle after edge E+MUL_LAT+1. For MUL_LAT=1 that is 2 edges.
- Throughput: one transfer per cycle sustained. Back-to-back alternating grants occur under continuous contention.
- Responses are returned in acceptance order. rsp0_valid and rsp1_valid are never high together.
- accN_cnt increments on each transfer by N and saturates at 2^CNT_W-1 (no wrap).
- busy = OR of all tag-stage v bits.
- Width rules:
  - Products pass through unmodified; the block performs no arithmetic on data.
  - Operands are passed bit-exact; no sign extension or rounding is applied.
- Reset (asserted low at any time, including mid-flight):
  - Immediately clears all tags, both rsp valids, rsp_cr/rsp_ci, m_ar/m_ai/m_br, and counters to 0; sets last_grant=1.
  - In-flight products are discarded with no response.
  - Readiness during reset follows the combinational equations (last_grant=1), but no state changes.
- The first edge after reset deassertion may accept a transfer.

Test Plan:
- Reset check: hold reset low → all outputs 0, busy=0; release, no valids for 10 cycles → rsp valids stay 0.
- Single request: req0 {ar=100, ai=-50, br=3} at edge E, MUL_LAT=1 → rsp0_valid high only in the cycle after E+2 with rsp_cr=300, rsp_ci=-150; acc0_cnt=1.
- Contention from reset: both valid continuously, req0 {1,2,5}, req1 {-7,4,-2} → grants alternate 0,1,0,1. Responses alternate {5,10} and {14,-8}. Never both readies or both rsp valids high.
- Mid-flight reset: assert reset one cycle after req1 transfers → no rsp1_valid ever appears; acc1_cnt=0; after release, req0 wins first contention.
- Saturation: CNT_W=4, req0 valid 20 consecutive cycles with req1 idle → acc0_cnt stops at 15; 20 rsp0 pulses are returned.
- Latency sweep: MUL_LAT=3 with a behavioural 3-stage multiplier → each transfer at edge E yields a response in the cycle after E+4; tag ids match 200 random transfers from both requesters.
